plru_table: RTL
===============

// Module: plru_table
// PURPOSE
//  Per-set tree-PLRU state store for the set-associative caches.
//  Holds ASSOCIATIVITY-1 tree bits per set and records accesses (touches).
//  Answers victim queries one cycle later.
//  Sits beside the tag/data arrays: the hit path drives touch_*, the refill path drives lookup_*.
// PARAMETERS
//  NUM_SETS       16  number of sets; power of 2, >=2
//  ASSOCIATIVITY   4  ways per set; power of 2, >=2; tree width W=ASSOCIATIVITY-1
// PORTS
//  clk            in   1          clock; all state on posedge
//  reset          in   1          synchronous, active-high
//  ready          out  1          1 = init sweep done, requests accepted
//  lookup_valid   in   1          victim query this cycle
//  lookup_index   in   $clog2(NUM_SETS)        set to query
//  victim_valid   out  1          victim_way valid (one cycle after lookup)
//  victim_way     out  $clog2(ASSOCIATIVITY)   way to replace
//  touch_valid    in   1          record access this cycle
//  touch_index    in   $clog2(NUM_SETS)        set accessed
//  touch_way      in   $clog2(ASSOCIATIVITY)   way accessed
// BEHAVIOUR
//  Tree: node 0 is root; node i has children 2i+1 (lower half) and 2i+2 (upper half).
//   Node bit 1 = victim lies in the upper half.
//  Victim walk: start at the root; at each level, append the node bit as the next way bit
//   (MSB first) and descend to the child that bit selects.
//  Touch of way w: each node on w's path is set to ~(w bit at that level); off-path nodes keep their value.
//   4-way case: node0=~w[1]; then node2=~w[0] if w[1]=1, else node1=~w[0].
//  FSM states INIT and RUN.
//   Reset (asserted at any time, including mid-sweep) -> INIT with sweep counter = 0.
//   INIT: writes all-zero tree to set[counter], counter++; after NUM_SETS cycles -> RUN.
//   INIT: ready=0; lookup_valid and touch_valid are ignored, no state change.
//  RUN: ready=1.
//   Touch writes the updated tree at posedge.
//   A lookup in cycle N registers the victim of set lookup_index at posedge N.
//    victim_valid=1 and victim_way appear during cycle N+1.
//   Bypass: touch and lookup of the same index in the same cycle -> victim uses the post-touch tree.
//   Lookup with no same-index touch in cycle N -> victim uses the stored tree.
//   victim_valid=0 in any cycle not preceded by an accepted lookup; victim_way holds its last value.
//   Simultaneous touch/lookup of different indices -> independent, both honoured.
//  Reset values: ready=0, victim_valid=0, victim_way=0, all trees 0, counter=0.
//  Widths: index and way are truncated to their declared widths; no out-of-range values are possible.
// CONFIGURATION
//  PLRU_TABLE_FLUSH_EN defined:
//   Adds input `flush` (1 bit).
//   flush=1 in RUN -> INIT next cycle (full re-sweep, ready drops next cycle).
//   Same-cycle touch/lookup is dropped; victim_valid=0 the following cycle.
//   flush=1 in INIT restarts the counter at 0.
//  PLRU_TABLE_FLUSH_EN undefined: no flush port; INIT is entered only via reset.
// TESTING
//  1 Reset 1 cycle, NUM_SETS=16 -> ready=0 for 16 cycles, then 1.
//    A lookup during INIT -> victim_valid stays 0.
//  2 After init, lookup idx 3 -> next cycle victim_valid=1, victim_way=0.
//  3 Idx 5, touch ways 0,2,1,3 in turn, each followed by a lookup -> victims 2,1,3,0.
//  4 Same cycle: touch idx 7 way 0 and lookup idx 7 -> victim 2 (bypass).
//    Same cycle: touch idx 7 way 0 and lookup idx 8 -> victim 0.
//  5 Touch idx 2 way 3, then reset asserted at sweep count 5 -> counter restarts.
//    After ready, lookup idx 2 -> victim 0.
//  6 (PLRU_TABLE_FLUSH_EN) Touch idx 1 way 0, flush -> ready low 16 cycles.
//    After ready, lookup idx 1 -> victim 0.

Source files
------------

// File: rtl/plru_table.sv
// rtl/plru_table.sv - per-set tree-PLRU state store with victim query (optional flush: PLRU_TABLE_FLUSH_EN)
module plru_table #(
    parameter int NUM_SETS      = 16,
    parameter int ASSOCIATIVITY = 4
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef PLRU_TABLE_FLUSH_EN
    input  logic                             flush,
`endif
    output logic                             ready,
    input  logic                             lookup_valid,
    input  logic [$clog2(NUM_SETS)-1:0]      lookup_index,
    output logic                             victim_valid,
    output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way,
    input  logic                             touch_valid,
    input  logic [$clog2(NUM_SETS)-1:0]      touch_index,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] touch_way
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(ASSOCIATIVITY);
    localparam int W     = ASSOCIATIVITY - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [W-1:0]       trees [NUM_SETS];
    logic [W-1:0]       touched_tree;
    logic [W-1:0]       lookup_tree;
    logic               flush_req;
    logic               touch_acc;
    logic               lookup_acc;

    // Walk from the root: each node bit becomes the next way bit (MSB first) and picks the child.
    function automatic logic [WAY_W-1:0] victim_of(input logic [W-1:0] tree);
        logic [WAY_W-1:0] way;
        logic [W-1:0]     sh;
        int               node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh   = tree >> node;
            way  = (way << 1) | WAY_W'(sh[0]);
            node = 2 * node + 1 + int'(sh[0]);
        end
        return way;
    endfunction

    // Point every node on the touched way's path away from it; off-path nodes are untouched.
    function automatic logic [W-1:0] touch_of(input logic [W-1:0] tree,
                                              input logic [WAY_W-1:0] way);
        logic [W-1:0]     t;
        logic [W-1:0]     mask;
        logic [WAY_W-1:0] sh;
        int               node;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh   = way >> (WAY_W - 1 - lvl);
            mask = W'(1) << node;
            t    = sh[0] ? (t & ~mask) : (t | mask);
            node = 2 * node + 1 + int'(sh[0]);
        end
        return t;
    endfunction

`ifdef PLRU_TABLE_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign ready        = (state_q == RUN);
    assign touch_acc    = ready && !flush_req && touch_valid;
    assign lookup_acc   = ready && !flush_req && lookup_valid;
    assign touched_tree = touch_of(trees[touch_index], touch_way);
    assign lookup_tree  = (touch_acc && touch_index == lookup_index) ? touched_tree
                                                                    : trees[lookup_index];

    // Next-state logic: sweep every set once in INIT; a flush restarts the sweep from set 0.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            INIT: begin
                if (flush_req) begin
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                    if (count_q == IDX_W'(NUM_SETS - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = INIT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = INIT;
                count_d = '0;
            end
        endcase
    end

    // State register and sweep counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Tree storage: cleared one set per cycle during INIT, updated by accepted touches in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                trees[count_q] <= '0;
            end else if (touch_acc) begin
                trees[touch_index] <= touched_tree;
            end
        end
    end

    // Victim register: valid pulses for one cycle per accepted lookup, way holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            victim_valid <= lookup_acc;
            if (lookup_acc) begin
                victim_way <= victim_of(lookup_tree);
            end
        end
    end

endmodule
